// File: rtl/sar_search_controller.sv
// Successive-approximation search controller: walks an 8-bit trial value MSB-first against an
// external three-way comparator, with optional early exit on equality and flag-fault detection.
module sar_search_controller #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       start,
  input  logic       pLessThanQ,
  input  logic       pEqualToQ,
  input  logic       pGreaterThanQ,
  output logic [7:0] trialQ,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       exact,
  output logic       cmpFault
);

  typedef enum logic [1:0] {StIdle, StApply, StSample, StDone} stateT;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  stateT      stateQ, stateD;
  logic [2:0] idxQ, idxD;
  logic [3:0] settleQ, settleD;
  logic [7:0] resultQ, resultD;
  logic       exactQ, exactD;
  logic       faultQ, faultD;
  logic [7:0] bitMask;
  logic [2:0] flags;

  assign bitMask  = 8'(1) << idxQ;
  assign busy     = (stateQ == StApply) || (stateQ == StSample);
  assign done     = (stateQ == StDone);
  assign trialQ   = busy ? (resultQ | bitMask) : resultQ;
  assign result   = resultQ;
  assign exact    = exactQ;
  assign cmpFault = faultQ;
  assign flags    = {pLessThanQ, pEqualToQ, pGreaterThanQ};

  always_comb begin
    stateD  = stateQ;
    idxD    = idxQ;
    settleD = settleQ;
    resultD = resultQ;
    exactD  = exactQ;
    faultD  = faultQ;
    case (stateQ)
      StIdle: begin
        if (start) begin
          resultD = 8'h00;
          exactD  = 1'b0;
          faultD  = 1'b0;
          idxD    = 3'd7;
          settleD = 4'd0;
          stateD  = StApply;
        end
      end
      StApply: begin
        if (settleQ == SettleLast) begin
          settleD = 4'd0;
          stateD  = StSample;
        end else begin
          settleD = settleQ + 4'd1;
        end
      end
      StSample: begin
        case (flags)
          3'b001, 3'b100: begin
            if (flags == 3'b001) resultD = resultQ | bitMask;
            if (idxQ == 3'd0) begin
              stateD = StDone;
            end else begin
              idxD   = idxQ - 3'd1;
              stateD = StApply;
            end
          end
          3'b010: begin
            resultD = resultQ | bitMask;
            exactD  = 1'b1;
            stateD  = StDone;
          end
          // No flag or several flags at once: comparator is broken, abandon the search.
          default: begin
            faultD  = 1'b1;
            resultD = 8'h00;
            stateD  = StDone;
          end
        endcase
      end
      StDone: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      stateQ  <= StIdle;
      idxQ    <= 3'd7;
      settleQ <= 4'd0;
      resultQ <= 8'h00;
      exactQ  <= 1'b0;
      faultQ  <= 1'b0;
    end else begin
      stateQ  <= stateD;
      idxQ    <= idxD;
      settleQ <= settleD;
      resultQ <= resultD;
      exactQ  <= exactD;
      faultQ  <= faultD;
    end
  end

endmodule

// File: tb/tb_sar_search_controller.sv
// Bench for sar_search_controller: an ideal comparator closes the loop around two instances
// (settle 1 and settle 3); results are checked against a closed-form binary-search model.
module tb_sar_search_controller;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic [7:0] pVal = 8'h00;
  logic [7:0] p3 = 8'h00;
  int         forceMode = 0;

  logic       pLess, pEq, pGt;
  logic [7:0] trialQ, result;
  logic       busy, done, exact, cmpFault;
  logic       pLess3, pEq3, pGt3;
  logic [7:0] trialQ3, result3;
  logic       busy3, done3, exact3, cmpFault3;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] seen[$];
  logic [7:0] resAtDone;
  logic       exAtDone, fltAtDone;

  always #5 clk = ~clk;

  // Ideal comparator, optionally overridden with illegal flag patterns.
  always_comb begin
    pLess = (pVal < trialQ);
    pEq   = (pVal == trialQ);
    pGt   = (pVal > trialQ);
    if (forceMode == 1) begin
      pLess = 1'b1;
      pEq   = 1'b0;
      pGt   = 1'b1;
    end else if (forceMode == 2) begin
      pLess = 1'b0;
      pEq   = 1'b0;
      pGt   = 1'b0;
    end
  end

  assign pLess3 = (p3 < trialQ3);
  assign pEq3   = (p3 == trialQ3);
  assign pGt3   = (p3 > trialQ3);

  sar_search_controller #(.SETTLE_CYCLES(1)) dut (
    .clock(clk), .resetN(resetN), .start(start),
    .pLessThanQ(pLess), .pEqualToQ(pEq), .pGreaterThanQ(pGt),
    .trialQ(trialQ), .busy(busy), .done(done), .result(result),
    .exact(exact), .cmpFault(cmpFault)
  );

  sar_search_controller #(.SETTLE_CYCLES(3)) dut3 (
    .clock(clk), .resetN(resetN), .start(start3),
    .pLessThanQ(pLess3), .pEqualToQ(pEq3), .pGreaterThanQ(pGt3),
    .trialQ(trialQ3), .busy(busy3), .done(done3), .result(result3),
    .exact(exact3), .cmpFault(cmpFault3)
  );

  typedef struct {
    logic [7:0] p;
    logic [7:0] expResult;
    logic       expExact;
    int         expLat;
  } vecT;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Binary search on P ends at the trial that tests P's lowest set bit (8 trials when P == 0).
  function automatic int expTrials(input logic [7:0] p);
    for (int i = 0; i < 8; i++) if (p[i]) return 8 - i;
    return 8;
  endfunction

  // Trial j keeps P's bits above the tested position and sets the tested bit.
  function automatic logic [7:0] expTrial(input logic [7:0] p, input int j);
    int i;
    int v;
    i = 7 - j;
    v = ((int'(p) >> (i + 1)) << (i + 1)) | (1 << i);
    return v[7:0];
  endfunction

  task automatic checkTrials(input logic [7:0] p, input int n);
    check("trialCount", seen.size(), n);
    for (int j = 0; j < n && j < seen.size(); j++)
      check($sformatf("trial%0d p=%0h", j, p), seen[j], expTrial(p, j));
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, ".trialQ"}, trialQ, 8'h00);
    check({tag, ".result"}, result, 8'h00);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".done"}, done, 1'b0);
    check({tag, ".exact"}, exact, 1'b0);
    check({tag, ".cmpFault"}, cmpFault, 1'b0);
  endtask

  // Starts a search on dut (also releasing reset), optionally injects a flag fault during
  // the given SAMPLE, and returns the edge count from the start edge to the done cycle.
  task automatic runSearch(input logic [7:0] p, input int mode, input int faultSample,
                           input bit midStart, output int lat);
    pVal = p;
    seen.delete();
    forceMode = 0;
    lat = -1;
    @(negedge clk);
    resetN = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busyAfterStart", busy, 1'b1);
    for (int e = 0; e < 200; e++) begin
      if (busy && (seen.size() == 0 || seen[$] !== trialQ)) seen.push_back(trialQ);
      forceMode = (mode != 0 && e == 2 * faultSample - 1) ? mode : 0;
      start = midStart && (e == 3);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = e + 1;
        break;
      end
    end
    forceMode = 0;
    if (lat < 0) check("doneTimeout", 0, 1);
    resAtDone = result;
    exAtDone  = exact;
    fltAtDone = cmpFault;
    start = 1'b1;  // must be ignored while done is high
    @(posedge clk);
    #1;
    start = 1'b0;
    check("donePulseOneCycle", done, 1'b0);
    check("startIgnoredInDone", busy, 1'b0);
    check("resultHeld", result, resAtDone);
    check("trialEqResultIdle", trialQ, resAtDone);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecT vecs[6];
    int  lat;
    logic [7:0] p;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 16};
    vecs[1] = '{8'h40, 8'h40, 1'b1, 4};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 16};
    vecs[3] = '{8'h47, 8'h47, 1'b1, 16};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 2};
    vecs[5] = '{8'h01, 8'h01, 1'b1, 16};

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    check("reset.trialQ3", trialQ3, 8'h00);

    foreach (vecs[i]) begin
      runSearch(vecs[i].p, 0, 0, 1'b0, lat);
      check($sformatf("latency p=%0h", vecs[i].p), lat, vecs[i].expLat);
      check($sformatf("result p=%0h", vecs[i].p), resAtDone, vecs[i].expResult);
      check($sformatf("exact p=%0h", vecs[i].p), exAtDone, vecs[i].expExact);
      check($sformatf("cmpFault p=%0h", vecs[i].p), fltAtDone, 1'b0);
      checkTrials(vecs[i].p, expTrials(vecs[i].p));
    end

    // Both flags high at the 3rd SAMPLE, with a start pulse mid-search that must be ignored.
    runSearch(8'h47, 1, 3, 1'b1, lat);
    check("fault2.latency", lat, 6);
    check("fault2.cmpFault", fltAtDone, 1'b1);
    check("fault2.result", resAtDone, 8'h00);
    check("fault2.exact", exAtDone, 1'b0);
    checkTrials(8'h47, 3);

    // No flags at all at the 1st SAMPLE.
    runSearch(8'h10, 2, 1, 1'b0, lat);
    check("fault0.latency", lat, 2);
    check("fault0.cmpFault", fltAtDone, 1'b1);
    check("fault0.result", resAtDone, 8'h00);

    for (int n = 0; n < 24; n++) begin
      p = 8'($urandom_range(0, 255));
      runSearch(p, 0, 0, 1'b0, lat);
      check($sformatf("rand.latency p=%0h", p), lat, 2 * expTrials(p));
      check($sformatf("rand.result p=%0h", p), resAtDone, p);
      check($sformatf("rand.exact p=%0h", p), exAtDone, (p != 8'h00));
      check($sformatf("rand.cmpFault p=%0h", p), fltAtDone, 1'b0);
      checkTrials(p, expTrials(p));
    end

    // Reset at cycle 7 of a search aborts it; the release edge also accepts a new start.
    pVal = 8'h47;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    resetN = 1'b0;
    @(posedge clk);
    #1;
    checkResetValues("midReset");
    runSearch(8'h47, 0, 0, 1'b0, lat);
    check("afterReset.latency", lat, 16);
    check("afterReset.result", resAtDone, 8'h47);
    check("afterReset.exact", exAtDone, 1'b1);

    // Settle of 3 cycles stretches every trial to 4 cycles.
    p3 = 8'h47;
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    lat = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      if (done3) begin
        lat = e;
        break;
      end
    end
    check("settle3.latency", lat, 32);
    check("settle3.result", result3, 8'h47);
    check("settle3.exact", exact3, 1'b1);
    check("settle3.cmpFault", cmpFault3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
